emaxi_single: RTL and testbench

- Emesh-to-AXI4 master bridge: the initiator end of the emesh/AXI slave path that feeds peripheral blocks.
- Accepts emesh write and read-request packets, issues single-beat 32-bit AXI transactions and returns read responses as emesh packets.
- Used where an emesh fabric must reach AXI-attached memory or peripherals.
- AXI len/burst/id/cache/prot/qos/lock are tied off at the instantiating level: len=0, INCR, id=0.

---
 rtl/emaxi_single.sv | 226 ++++++++++++++++++++++
 tb/tb_emaxi_single.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/emaxi_single.sv
// Emesh-to-AXI4 single-beat master bridge: posted writes, and reads whose data
// comes back to the emesh fabric as read-response packets.
module emaxi_single #(
    parameter int AW = 32,
    parameter int PW = 2*AW+40
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          wr_access,
    input  logic [PW-1:0] wr_packet,
    output logic          wr_wait,
    input  logic          rd_access,
    input  logic [PW-1:0] rd_packet,
    output logic          rd_wait,
    output logic          rr_access,
    output logic [PW-1:0] rr_packet,
    input  logic          rr_wait,
    output logic [31:0]   m_axi_awaddr,
    output logic [2:0]    m_axi_awsize,
    output logic          m_axi_awvalid,
    input  logic          m_axi_awready,
    output logic [31:0]   m_axi_wdata,
    output logic [3:0]    m_axi_wstrb,
    output logic          m_axi_wlast,
    output logic          m_axi_wvalid,
    input  logic          m_axi_wready,
    input  logic [1:0]    m_axi_bresp,
    input  logic          m_axi_bvalid,
    output logic          m_axi_bready,
    output logic [31:0]   m_axi_araddr,
    output logic [2:0]    m_axi_arsize,
    output logic          m_axi_arvalid,
    input  logic          m_axi_arready,
    input  logic [31:0]   m_axi_rdata,
    input  logic [1:0]    m_axi_rresp,
    input  logic          m_axi_rvalid,
    output logic          m_axi_rready,
    output logic          axi_err
);

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} rstate_t;

    function automatic logic [2:0] size_of(input logic [1:0] dm);
        return (dm == 2'd3) ? 3'd2 : {1'b0, dm};
    endfunction

    function automatic logic [3:0] strb_of(input logic [1:0] dm, input logic [1:0] off);
        case (dm)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0] dm, input logic [31:0] d);
        case (dm)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Bring the addressed lane down to bit 0 and clear everything above the access size.
    function automatic logic [31:0] rdata_of(input logic [1:0] dm, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [31:0] s;
        s = d >> {off, 3'b000};
        case (dm)
            2'd0:    return {24'h0, s[7:0]};
            2'd1:    return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // ---------------- write path ----------------
    wstate_t     wstate_q, wstate_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        wr_accept;
    logic [31:0] awaddr_q, wdata_q;
    logic [2:0]  awsize_q;
    logic [3:0]  wstrb_q;

    always_comb begin
        wstate_d      = wstate_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        wr_accept     = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (wr_access) begin
                    wr_accept = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wstate_d  = W_SEND;
                end
            end
            W_SEND: begin
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          wstate_d  = W_RESP;
            end
            W_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wstate_q  <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (wr_accept) begin
                awaddr_q <= wr_packet[39:8];
                awsize_q <= size_of(wr_packet[2:1]);
                wdata_q  <= wdata_of(wr_packet[2:1], wr_packet[71:40]);
                wstrb_q  <= strb_of(wr_packet[2:1], wr_packet[9:8]);
            end
        end
    end

    assign wr_wait      = (wstate_q != W_IDLE);
    assign m_axi_awaddr = awaddr_q;
    assign m_axi_awsize = awsize_q;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;
    assign m_axi_wlast  = 1'b1;

    // ---------------- read path ----------------
    rstate_t     rstate_q, rstate_d;
    logic        rd_accept, r_fire;
    logic [1:0]  rd_dm_q;
    logic [4:0]  rd_ctrl_q;
    logic [31:0] rd_dst_q, rd_src_q, rr_data_q;

    always_comb begin
        rstate_d      = rstate_q;
        rd_accept     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        rr_access     = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (rd_access) begin
                    rd_accept = 1'b1;
                    rstate_d  = R_ADDR;
                end
            end
            R_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) rstate_d = R_DATA;
            end
            R_DATA: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) rstate_d = R_RESP;
            end
            R_RESP: begin
                rr_access = 1'b1;
                if (!rr_wait) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    assign r_fire = m_axi_rvalid && m_axi_rready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rstate_q  <= R_IDLE;
            rd_dm_q   <= '0;
            rd_ctrl_q <= '0;
            rd_dst_q  <= '0;
            rd_src_q  <= '0;
            rr_data_q <= '0;
        end else begin
            rstate_q <= rstate_d;
            if (rd_accept) begin
                rd_dm_q   <= rd_packet[2:1];
                rd_ctrl_q <= rd_packet[7:3];
                rd_dst_q  <= rd_packet[39:8];
                rd_src_q  <= rd_packet[103:72];
            end
            if (r_fire) rr_data_q <= rdata_of(rd_dm_q, rd_dst_q[1:0], m_axi_rdata);
        end
    end

    assign rd_wait      = (rstate_q != R_IDLE);
    assign m_axi_araddr = rd_dst_q;
    assign m_axi_arsize = size_of(rd_dm_q);
    // Response returns to the requester: addresses swap, write bit marks it as a response.
    assign rr_packet    = {rd_dst_q, rr_data_q, rd_src_q, rd_ctrl_q, rd_dm_q, 1'b1};

    // ---------------- sticky error ----------------
    logic err_q;
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_q <= 1'b0;
        end else if ((m_axi_bvalid && m_axi_bready && m_axi_bresp[1]) ||
                     (r_fire && m_axi_rresp[1])) begin
            err_q <= 1'b1;
        end
    end
    assign axi_err = err_q;

    logic unused_ok;
    assign unused_ok = ^{wr_packet[103:72], wr_packet[7:3], wr_packet[0],
                         rd_packet[71:40], rd_packet[0], m_axi_bresp[0], m_axi_rresp[0]};

endmodule

// File: tb/tb_emaxi_single.sv
// Directed bench for emaxi_single: table of single transactions plus
// hand-built sequences for handshake skew, response stall, concurrency and reset.
module tb_emaxi_single;
    localparam int PW = 104;

    logic          clk = 1'b0;
    logic          nreset;
    logic          wr_access, rd_access, rr_access, rr_wait, wr_wait, rd_wait;
    logic [PW-1:0] wr_packet, rd_packet, rr_packet;
    logic [31:0]   awaddr, wdata, araddr, rdata;
    logic [2:0]    awsize, arsize;
    logic [3:0]    wstrb;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, axi_err;
    logic [1:0]    bresp, rresp;

    int total = 0;
    int bad   = 0;
    int aw_beats = 0;
    int w_beats  = 0;

    always #5 clk = ~clk;

    emaxi_single dut (
        .clk(clk), .nreset(nreset),
        .wr_access(wr_access), .wr_packet(wr_packet), .wr_wait(wr_wait),
        .rd_access(rd_access), .rd_packet(rd_packet), .rd_wait(rd_wait),
        .rr_access(rr_access), .rr_packet(rr_packet), .rr_wait(rr_wait),
        .m_axi_awaddr(awaddr), .m_axi_awsize(awsize), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arsize(arsize), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .axi_err(axi_err)
    );

    always @(posedge clk) begin
        if (awvalid && awready) aw_beats <= aw_beats + 1;
        if (wvalid && wready)   w_beats  <= w_beats + 1;
    end

    typedef struct {
        logic        is_rd;
        logic [1:0]  dm;
        logic [4:0]  ctrl;
        logic [31:0] dst;
        logic [31:0] data;
        logic [31:0] src;
        logic [31:0] rd_bus;
        logic [2:0]  exp_size;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rr;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [PW-1:0] mk_pkt(input logic wr, input logic [1:0] dm,
                                             input logic [4:0] ctrl, input logic [31:0] dst,
                                             input logic [31:0] data, input logic [31:0] src);
        return {src, data, dst, ctrl, dm, wr};
    endfunction

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        wr_access = 0; rd_access = 0; rr_wait = 0;
        wr_packet = '0; rd_packet = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = '0;
    endtask

    task automatic run_write(input int i, input vec_t v);
        @(negedge clk);
        wr_access = 1; wr_packet = mk_pkt(1'b1, v.dm, v.ctrl, v.dst, v.data, v.src);
        @(negedge clk);
        wr_access = 0;
        for (int k = 0; k < 20 && !awvalid; k++) @(negedge clk);
        check($sformatf("v%0d awvalid", i), awvalid, 1'b1);
        check($sformatf("v%0d wvalid", i), wvalid, 1'b1);
        check($sformatf("v%0d awaddr", i), awaddr, v.dst);
        check($sformatf("v%0d awsize", i), awsize, v.exp_size);
        check($sformatf("v%0d wstrb", i), wstrb, v.exp_strb);
        check($sformatf("v%0d wdata", i), wdata, v.exp_wdata);
        check($sformatf("v%0d wlast", i), wlast, 1'b1);
        awready = 1; wready = 1;
        @(negedge clk);
        awready = 0; wready = 0;
        check($sformatf("v%0d bready", i), bready, 1'b1);
        bvalid = 1;
        @(negedge clk);
        bvalid = 0;
        check($sformatf("v%0d wr_wait after b", i), wr_wait, 1'b0);
        $display("write v%0d dst=%h strb=%h wdata=%h", i, awaddr, wstrb, wdata);
    endtask

    task automatic run_read(input int i, input vec_t v);
        @(negedge clk);
        rd_access = 1; rd_packet = mk_pkt(1'b0, v.dm, v.ctrl, v.dst, v.data, v.src);
        @(negedge clk);
        rd_access = 0;
        for (int k = 0; k < 20 && !arvalid; k++) @(negedge clk);
        check($sformatf("v%0d arvalid", i), arvalid, 1'b1);
        check($sformatf("v%0d araddr", i), araddr, v.dst);
        check($sformatf("v%0d arsize", i), arsize, v.exp_size);
        arready = 1;
        @(negedge clk);
        arready = 0;
        check($sformatf("v%0d rready", i), rready, 1'b1);
        rvalid = 1; rdata = v.rd_bus;
        @(negedge clk);
        rvalid = 0;
        for (int k = 0; k < 20 && !rr_access; k++) @(negedge clk);
        check($sformatf("v%0d rr_access", i), rr_access, 1'b1);
        check($sformatf("v%0d rr_packet", i), rr_packet,
              mk_pkt(1'b1, v.dm, v.ctrl, v.src, v.exp_rr, v.dst));
        @(negedge clk);
        check($sformatf("v%0d rd_wait idle", i), rd_wait, 1'b0);
        $display("read v%0d addr=%h rr_data=%h", i, v.dst, rr_packet[71:40]);
    endtask

    initial begin
        logic [PW-1:0] exp_pkt;
        int aw0, w0;

        //        rd  dm    ctrl   dst           data          src           rdata         sz  strb     wdata         rr
        vecs[0] = '{0, 2'd2, 5'h01, 32'h81000004, 32'hDEADBEEF, 32'h0,        32'h0,        3'd2, 4'hF,    32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 2'd0, 5'h02, 32'h81000003, 32'h0000005A, 32'h0,        32'h0,        3'd0, 4'b1000, 32'h5A5A5A5A, 32'h0};
        vecs[2] = '{0, 2'd1, 5'h03, 32'h81000002, 32'h0000BEEF, 32'h0,        32'h0,        3'd1, 4'b1100, 32'hBEEFBEEF, 32'h0};
        vecs[3] = '{0, 2'd0, 5'h04, 32'h81000001, 32'h12345677, 32'h0,        32'h0,        3'd0, 4'b0010, 32'h77777777, 32'h0};
        vecs[4] = '{0, 2'd3, 5'h05, 32'h80000010, 32'h01020304, 32'h0,        32'h0,        3'd2, 4'hF,    32'h01020304, 32'h0};
        vecs[5] = '{1, 2'd1, 5'h15, 32'h80000002, 32'h0,        32'h82000000, 32'h1234ABCD, 3'd1, 4'h0,    32'h0,        32'h00001234};
        vecs[6] = '{1, 2'd0, 5'h0A, 32'h80000003, 32'h0,        32'h82000010, 32'hA1B2C3D4, 3'd0, 4'h0,    32'h0,        32'h000000A1};
        vecs[7] = '{1, 2'd0, 5'h1F, 32'h80000001, 32'h0,        32'h82000020, 32'hA1B2C3D4, 3'd0, 4'h0,    32'h0,        32'h000000C3};
        vecs[8] = '{1, 2'd2, 5'h00, 32'h80000008, 32'h0,        32'h82000030, 32'hCAFEF00D, 3'd2, 4'h0,    32'h0,        32'hCAFEF00D};
        vecs[9] = '{1, 2'd1, 5'h11, 32'h80000000, 32'h0,        32'h82000040, 32'h1234ABCD, 3'd1, 4'h0,    32'h0,        32'h0000ABCD};

        clear_inputs();
        nreset = 0;
        repeat (3) @(negedge clk);
        check("reset wr_wait", wr_wait, 1'b0);
        check("reset rd_wait", rd_wait, 1'b0);
        check("reset awvalid", awvalid, 1'b0);
        check("reset wvalid", wvalid, 1'b0);
        check("reset arvalid", arvalid, 1'b0);
        check("reset rr_access", rr_access, 1'b0);
        check("reset axi_err", axi_err, 1'b0);
        nreset = 1;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_rd) run_read(i, vecs[i]);
            else               run_write(i, vecs[i]);
        end

        // Write data accepted three cycles ahead of the address: one beat each.
        @(negedge clk);
        aw0 = aw_beats; w0 = w_beats;
        wr_access = 1; wr_packet = mk_pkt(1'b1, 2'd0, 5'h0, 32'h81000003, 32'h5A, 32'h0);
        @(negedge clk);
        wr_access = 0; wready = 1;
        check("skew wstrb", wstrb, 4'b1000);
        check("skew wdata", wdata, 32'h5A5A5A5A);
        repeat (3) begin
            @(negedge clk);
            check("skew wvalid low", wvalid, 1'b0);
            check("skew awvalid high", awvalid, 1'b1);
        end
        awready = 1;
        @(negedge clk);
        awready = 0; wready = 0;
        check("skew bready", bready, 1'b1);
        check("skew w beats", w_beats - w0, 1);
        check("skew aw beats", aw_beats - aw0, 1);
        bvalid = 1;
        @(negedge clk);
        bvalid = 0;
        check("skew wr_wait", wr_wait, 1'b0);
        $display("skewed byte write: aw_beats=%0d w_beats=%0d", aw_beats - aw0, w_beats - w0);

        // Read response stalled by rr_wait for five cycles.
        rd_access = 1; rd_packet = mk_pkt(1'b0, 2'd1, 5'h07, 32'h80000002, 32'h0, 32'h82000000);
        rr_wait = 1;
        @(negedge clk);
        rd_access = 0; arready = 1;
        @(negedge clk);
        arready = 0; rvalid = 1; rdata = 32'h1234ABCD;
        @(negedge clk);
        rvalid = 0; rdata = 32'hFFFFFFFF;
        exp_pkt = mk_pkt(1'b1, 2'd1, 5'h07, 32'h82000000, 32'h00001234, 32'h80000002);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d rr_access", c), rr_access, 1'b1);
            check($sformatf("stall%0d rr_packet", c), rr_packet, exp_pkt);
            check($sformatf("stall%0d rd_wait", c), rd_wait, 1'b1);
            @(negedge clk);
        end
        rr_wait = 0;
        @(negedge clk);
        check("stall release rr_access", rr_access, 1'b0);
        check("stall release rd_wait", rd_wait, 1'b0);
        $display("stalled read: response held 5 cycles, data=%h", exp_pkt[71:40]);

        // Concurrent write and read, read returns SLVERR.
        wr_access = 1; wr_packet = mk_pkt(1'b1, 2'd2, 5'h0, 32'h81000000, 32'h11223344, 32'h0);
        rd_access = 1; rd_packet = mk_pkt(1'b0, 2'd2, 5'h0, 32'h80000004, 32'h0, 32'h82000004);
        @(negedge clk);
        wr_access = 0; rd_access = 0;
        check("conc awvalid", awvalid, 1'b1);
        check("conc arvalid", arvalid, 1'b1);
        awready = 1; wready = 1; arready = 1;
        @(negedge clk);
        awready = 0; wready = 0; arready = 0;
        bvalid = 1; rvalid = 1; rdata = 32'h55667788; rresp = 2'b10;
        @(negedge clk);
        bvalid = 0; rvalid = 0; rresp = 2'b00;
        check("conc axi_err", axi_err, 1'b1);
        check("conc wr_wait", wr_wait, 1'b0);
        check("conc rr data", rr_packet[71:40], 32'h55667788);
        repeat (2) @(negedge clk);
        check("conc axi_err sticky", axi_err, 1'b1);
        check("conc rd_wait", rd_wait, 1'b0);
        $display("concurrent wr+rd: axi_err=%0b", axi_err);

        // Reset asserted mid W_SEND abandons the write.
        wr_access = 1; wr_packet = mk_pkt(1'b1, 2'd2, 5'h0, 32'h81000008, 32'hA5A5A5A5, 32'h0);
        @(negedge clk);
        wr_access = 0;
        check("rst awvalid before", awvalid, 1'b1);
        #2 nreset = 0;
        #1;
        check("rst awvalid", awvalid, 1'b0);
        check("rst wvalid", wvalid, 1'b0);
        check("rst bready", bready, 1'b0);
        check("rst wr_wait", wr_wait, 1'b0);
        check("rst rd_wait", rd_wait, 1'b0);
        check("rst axi_err", axi_err, 1'b0);
        @(negedge clk);
        nreset = 1;
        @(negedge clk);
        check("post rst wr_wait", wr_wait, 1'b0);
        check("post rst bready", bready, 1'b0);
        $display("reset during W_SEND: awvalid=%0b wvalid=%0b", awvalid, wvalid);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
